spi_slave_port: RTL and testbench
=================================

Name: spi_slave_port

Overview:
- SPI slave endpoint for the AES core; the far end of the team's SPI master.
- Accepts one frame per chip-select assertion: key bits plus one data block.
- Returns one result block (ciphertext or plaintext) on miso during the same frame.
- Mode 0, MSB first.
- All SPI inputs are oversampled and synchronised into the single system clock `clk`.

Parameters:
- Nk, 4, key length in 32-bit words (4/6/8).
- datasize, 128, data block width in bits; also the width of the returned result.
- FRAME_BITS (localparam), datasize + Nk*32, bits received per frame.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from master; asynchronous to clk.
- scs  in  1  chip select, active-low, asynchronous.
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master.
- rx_data  out  FRAME_BITS  last complete received frame; first received bit at the MSB.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_data  in  datasize  result word to return in the next frame.
- tx_valid  in  1  tx_data offered.
- tx_ready  out  1  tx holding register empty; transfer occurs when tx_valid && tx_ready.
- busy  out  1  frame in progress (state SHIFT or DONE).
- frame_err  out  1  one-cycle pulse: scs deasserted before FRAME_BITS bits were received.
- tx_underrun  out  1  one-cycle pulse: frame started with no tx word pending.

Behaviour:
- Reset state (rst low, async):
  - state IDLE, shifters and bit counter cleared.
  - miso 0, rx_data 0, rx_valid 0, busy 0, frame_err 0, tx_underrun 0.
  - tx_ready 1, pending flag 0.
- Synchronisers and edge detection:
  - sclk, scs and mosi each pass through a 2-flop synchroniser.
  - A third flop on sclk/scs gives rise/fall detection.
  - Requirement: sclk half-period ≥ 4 clk cycles; behaviour is undefined if faster.
- TX holding register:
  - On tx_valid && tx_ready: capture tx_data, set pending, drop tx_ready next cycle.
- States:
  - IDLE: on synchronised scs fall:
    - load tx shifter from the holding register if pending, and clear pending (tx_ready returns to 1 next cycle).
    - If a handshake occurs in the same cycle as the scs fall, tx_data goes straight to the shifter and pending stays 0.
    - If neither source is available, load all zeros and pulse tx_underrun.
    - Clear bit_cnt and go to SHIFT.
    - miso = shifter MSB from the cycle after the load, so the first bit is valid before the first sclk rise.
  - SHIFT:
    - On each synchronised sclk rise: rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_sync}; bit_cnt++.
    - On each sclk fall: shift the tx shifter left, filling with 0. miso follows the new MSB.
    - After datasize shifts miso stays 0 for the rest of the frame.
    - When the rise that completes bit FRAME_BITS is seen: rx_data <= final shift value (including that bit), rx_valid pulses next cycle, go to DONE.
  - DONE: ignore sclk edges; miso 0; on scs rise go to IDLE.
  - Any state other than IDLE on scs rise before bit_cnt reaches FRAME_BITS:
    - pulse frame_err, go to IDLE.
    - rx_data unchanged, no rx_valid, partial rx_shift discarded.
    - The unsent tx word is lost, not re-queued.
- scs rise coinciding with the completing sclk rise: the frame counts as complete (rx_valid pulses, no frame_err); go to IDLE directly.
- miso is 0 whenever state is IDLE; no tri-state.
- busy = (state != IDLE).
- A pending tx word persists across idle periods until a frame consumes it or reset.
- Reset asserted mid-frame: immediate return to reset values. The frame in progress and any pending tx word are lost.

Test Plan:
- Nk=4, pending tx = 128'h3925841d02dc09fbdc118597196a0b32. Master sends 256 bits {key 2b7e1516…09cf4f3c, data 3243f6a8…e0370734}. Required:
  - rx_data equals that 256-bit value.
  - rx_valid pulses exactly once.
  - miso bits 0..127 equal the tx word MSB-first; bits 128..255 are 0.
- Abort after 100 sclk rises (scs deasserted) -> frame_err one pulse, no rx_valid, rx_data keeps its prior value; the next full frame is received correctly.
- No tx word loaded before scs fall -> tx_underrun pulse, miso all 0 for 256 bits; reception still correct.
- tx_valid && tx_ready in the same cycle as the synchronised scs fall with tx_data=128'hA5A5…A5 -> first miso bit 1, pattern A5 repeating, pending 0, tx_ready stays 1.
- Reset low at bit 57 of a frame -> all outputs go to reset values within the same cycle; after release a full frame completes normally.
- Master sends 300 sclk pulses in one frame -> rx_valid after bit 256, extra edges ignored, no frame_err on scs rise.

Source files
------------

// File: rtl/spi_slave_port.sv
// spi_slave_port: SPI mode-0 slave endpoint for the AES core.
// Each chip-select frame carries key bits followed by one data block
// (MSB first). The same frame returns one result block on miso.
// All SPI pins are synchronised into clk. The design never samples on sclk.
//
// Ports:
//   clk, rst           system clock, asynchronous active-low reset
//   sclk, scs, mosi    SPI inputs from the master (asynchronous to clk)
//   miso               serial result to the master
//   rx_data/rx_valid   last complete received frame, plus a one-cycle update pulse
//   tx_data/tx_valid/tx_ready  result word handshake into the holding register
//   busy               a frame is in progress
//   frame_err          one-cycle pulse when a frame is aborted early
//   tx_underrun        one-cycle pulse when a frame starts with no result word
module spi_slave_port #(
    parameter int unsigned Nk       = 4,
    parameter int unsigned datasize = 128
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sclk,
    input  logic                                 scs,
    input  logic                                 mosi,
    output logic                                 miso,
    output logic [datasize + Nk*32 - 1:0]        rx_data,
    output logic                                 rx_valid,
    input  logic [datasize-1:0]                  tx_data,
    input  logic                                 tx_valid,
    output logic                                 tx_ready,
    output logic                                 busy,
    output logic                                 frame_err,
    output logic                                 tx_underrun
);

    localparam int unsigned FRAME_BITS = datasize + Nk*32;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state, state_nx;

    // Two synchroniser flops, plus a third flop on sclk/scs for edge detection
    logic [2:0]              sclk_q, scs_q;
    logic [1:0]              mosi_q;

    logic [FRAME_BITS-1:0]   rx_shift, rx_shift_nx;
    logic [CNT_W-1:0]        bit_cnt, bit_cnt_nx;
    logic [datasize-1:0]     tx_shift, tx_shift_nx;
    logic [datasize-1:0]     hold, hold_nx;
    logic                    pending, pending_nx;
    logic [FRAME_BITS-1:0]   rx_data_nx;
    logic                    rx_valid_nx, frame_err_nx, underrun_nx;
    logic                    miso_nx, busy_nx;

    logic                    sclk_rise_c, sclk_fall_c, scs_fall_c, scs_rise_c;
    logic                    mosi_bit_c, tx_hs_c, last_bit_c;

    assign sclk_rise_c = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall_c = ~sclk_q[1] & sclk_q[2];
    assign scs_fall_c  = ~scs_q[1] & scs_q[2];
    assign scs_rise_c  = scs_q[1] & ~scs_q[2];
    assign mosi_bit_c  = mosi_q[1];
    assign tx_hs_c     = tx_valid & tx_ready;
    assign last_bit_c  = sclk_rise_c && (bit_cnt == CNT_W'(FRAME_BITS - 1));

    // Next-state and next-output logic
    always_comb begin
        state_nx     = state;
        rx_shift_nx  = rx_shift;
        bit_cnt_nx   = bit_cnt;
        tx_shift_nx  = tx_shift;
        hold_nx      = hold;
        pending_nx   = pending;
        rx_data_nx   = rx_data;
        rx_valid_nx  = 1'b0;
        frame_err_nx = 1'b0;
        underrun_nx  = 1'b0;

        if (tx_hs_c) begin
            hold_nx    = tx_data;
            pending_nx = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (scs_fall_c) begin
                    // pending and a handshake are exclusive: tx_ready mirrors !pending
                    if (pending) begin
                        tx_shift_nx = hold;
                        pending_nx  = 1'b0;
                    end else if (tx_hs_c) begin
                        tx_shift_nx = tx_data;
                        pending_nx  = 1'b0;
                    end else begin
                        tx_shift_nx = '0;
                        underrun_nx = 1'b1;
                    end
                    bit_cnt_nx  = '0;
                    rx_shift_nx = '0;
                    state_nx    = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_fall_c) begin
                    tx_shift_nx = {tx_shift[datasize-2:0], 1'b0};
                end
                if (sclk_rise_c) begin
                    rx_shift_nx = {rx_shift[FRAME_BITS-2:0], mosi_bit_c};
                    bit_cnt_nx  = bit_cnt + CNT_W'(1);
                end
                if (last_bit_c) begin
                    // A coincident scs rise still counts as a complete frame
                    rx_data_nx  = rx_shift_nx;
                    rx_valid_nx = 1'b1;
                    state_nx    = scs_rise_c ? IDLE : DONE;
                end else if (scs_rise_c) begin
                    frame_err_nx = 1'b1;
                    state_nx     = IDLE;
                end
            end
            DONE: begin
                if (scs_rise_c) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        miso_nx = (state_nx == SHIFT) ? tx_shift_nx[datasize-1] : 1'b0;
        busy_nx = (state_nx != IDLE);
    end

    // State, synchronisers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sclk_q      <= '0;
            scs_q       <= '1;
            mosi_q      <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            tx_shift    <= '0;
            hold        <= '0;
            pending     <= 1'b0;
            tx_ready    <= 1'b1;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
            miso        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            sclk_q      <= {sclk_q[1:0], sclk};
            scs_q       <= {scs_q[1:0], scs};
            mosi_q      <= {mosi_q[0], mosi};
            rx_shift    <= rx_shift_nx;
            bit_cnt     <= bit_cnt_nx;
            tx_shift    <= tx_shift_nx;
            hold        <= hold_nx;
            pending     <= pending_nx;
            tx_ready    <= ~pending_nx;
            rx_data     <= rx_data_nx;
            rx_valid    <= rx_valid_nx;
            frame_err   <= frame_err_nx;
            tx_underrun <= underrun_nx;
            miso        <= miso_nx;
            busy        <= busy_nx;
        end
    end

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port (Nk=4, datasize=128, 256-bit frames).
// The bench acts as an SPI mode-0 master and samples miso on each sclk rise.
module tb_spi_slave_port;

    localparam int HALF = 50;   // sclk half period in ns (5 clk cycles)

    logic         clk = 1'b0;
    logic         rst;
    logic         sclk, scs, mosi;
    logic         miso;
    logic [255:0] rx_data;
    logic         rx_valid;
    logic [127:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         frame_err;
    logic         tx_underrun;

    int tests = 0;
    int fails = 0;

    // Pulse counters
    int n_rxv = 0;
    int n_ferr = 0;
    int n_und = 0;

    logic [255:0] mcap;
    logic         hs_ready;
    logic         snap_ready_pre, snap_ready, snap_miso, snap_busy, snap_rxv, snap_ferr, snap_und;
    logic [255:0] snap_rx;

    localparam logic [127:0] KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] DATA  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] TXW   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] A5W   = {16{8'hA5}};
    localparam logic [255:0] FRAME = {KEY, DATA};
    localparam logic [255:0] PAT2  = ~{KEY, DATA};
    localparam logic [255:0] PAT3  = {DATA, KEY};

    spi_slave_port #(.Nk(4), .datasize(128)) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .scs         (scs),
        .mosi        (mosi),
        .miso        (miso),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .tx_underrun (tx_underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid === 1'b1)    n_rxv++;
        if (frame_err === 1'b1)   n_ferr++;
        if (tx_underrun === 1'b1) n_und++;
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic [127:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    // One SPI frame. hs: offer hsdata exactly in the synchronised scs-fall cycle.
    // rst_bit >= 0: push a tx word, then reset the DUT before that bit.
    task automatic frame(input logic [255:0] vec, input int nbits, input bit hs,
                         input logic [127:0] hsdata, input int rst_bit);
        mcap = '0;
        if (hs) begin
            @(posedge clk); #1 scs = 1'b0;
            @(posedge clk); @(posedge clk);
            #1 tx_valid = 1'b1; tx_data = hsdata;
            @(posedge clk);
            #1 tx_valid = 1'b0;
            hs_ready = tx_ready;
        end else begin
            scs = 1'b0;
        end
        #100;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                push_tx(A5W);
                snap_ready_pre = tx_ready;
                #3 rst = 1'b0;
                #1;
                snap_ready = tx_ready;
                snap_miso  = miso;
                snap_busy  = busy;
                snap_rx    = rx_data;
                snap_rxv   = rx_valid;
                snap_ferr  = frame_err;
                snap_und   = tx_underrun;
                scs  = 1'b1;
                sclk = 1'b0;
                mosi = 1'b0;
                #20 rst = 1'b1;
                #200;
                return;
            end
            mosi = (i < 256) ? vec[255 - i] : 1'b0;
            #HALF sclk = 1'b1;
            if (i < 256) mcap[255 - i] = miso;
            #HALF sclk = 1'b0;
        end
        #HALF scs = 1'b1;
        mosi = 1'b0;
        #300;
    endtask

    int b_rxv, b_ferr, b_und;

    initial begin
        rst = 1'b0; sclk = 1'b0; scs = 1'b1; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = '0;
        hs_ready = 1'b0;
        #12;
        check("rst_miso",      256'(miso), 256'd0);
        check("rst_rx_data",   rx_data, 256'd0);
        check("rst_rx_valid",  256'(rx_valid), 256'd0);
        check("rst_busy",      256'(busy), 256'd0);
        check("rst_frame_err", 256'(frame_err), 256'd0);
        check("rst_underrun",  256'(tx_underrun), 256'd0);
        check("rst_tx_ready",  256'(tx_ready), 256'd1);
        #10 rst = 1'b1;
        #30;

        // Nominal frame with a pending result word
        push_tx(TXW);
        check("pend_tx_ready", 256'(tx_ready), 256'd0);
        b_rxv = n_rxv; b_ferr = n_ferr; b_und = n_und;
        frame(FRAME, 256, 1'b0, '0, -1);
        check("f1_rx_data",   rx_data, FRAME);
        check("f1_rxv_cnt",   256'(n_rxv - b_rxv), 256'd1);
        check("f1_miso",      mcap, {TXW, 128'h0});
        check("f1_ferr_cnt",  256'(n_ferr - b_ferr), 256'd0);
        check("f1_und_cnt",   256'(n_und - b_und), 256'd0);
        check("f1_busy",      256'(busy), 256'd0);
        check("f1_tx_ready",  256'(tx_ready), 256'd1);

        // Abort after 100 bits
        b_rxv = n_rxv; b_ferr = n_ferr;
        frame(PAT2, 100, 1'b0, '0, -1);
        check("ab_ferr_cnt",  256'(n_ferr - b_ferr), 256'd1);
        check("ab_rxv_cnt",   256'(n_rxv - b_rxv), 256'd0);
        check("ab_rx_data",   rx_data, FRAME);
        check("ab_busy",      256'(busy), 256'd0);

        // Full frame with no result word: underrun, miso all zero
        b_rxv = n_rxv; b_ferr = n_ferr; b_und = n_und;
        frame(PAT2, 256, 1'b0, '0, -1);
        check("un_rx_data",   rx_data, PAT2);
        check("un_rxv_cnt",   256'(n_rxv - b_rxv), 256'd1);
        check("un_und_cnt",   256'(n_und - b_und), 256'd1);
        check("un_miso",      mcap, 256'd0);
        check("un_ferr_cnt",  256'(n_ferr - b_ferr), 256'd0);

        // Handshake coinciding with the synchronised scs fall
        b_rxv = n_rxv; b_und = n_und;
        frame(PAT3, 256, 1'b1, A5W, -1);
        check("hs_tx_ready",  256'(hs_ready), 256'd1);
        check("hs_miso",      mcap, {A5W, 128'h0});
        check("hs_und_cnt",   256'(n_und - b_und), 256'd0);
        check("hs_rx_data",   rx_data, PAT3);
        check("hs_rxv_cnt",   256'(n_rxv - b_rxv), 256'd1);
        check("hs_tx_ready2", 256'(tx_ready), 256'd1);

        // Reset at bit 57 with a pending word queued mid-frame
        push_tx(TXW);
        frame(FRAME, 256, 1'b0, '0, 57);
        check("mr_ready_pre", 256'(snap_ready_pre), 256'd0);
        check("mr_tx_ready",  256'(snap_ready), 256'd1);
        check("mr_miso",      256'(snap_miso), 256'd0);
        check("mr_busy",      256'(snap_busy), 256'd0);
        check("mr_rx_data",   snap_rx, 256'd0);
        check("mr_rx_valid",  256'(snap_rxv), 256'd0);
        check("mr_frame_err", 256'(snap_ferr), 256'd0);
        check("mr_underrun",  256'(snap_und), 256'd0);
        b_rxv = n_rxv; b_und = n_und; b_ferr = n_ferr;
        frame(FRAME, 256, 1'b0, '0, -1);
        check("ar_rx_data",   rx_data, FRAME);
        check("ar_rxv_cnt",   256'(n_rxv - b_rxv), 256'd1);
        check("ar_und_cnt",   256'(n_und - b_und), 256'd1);
        check("ar_ferr_cnt",  256'(n_ferr - b_ferr), 256'd0);

        // 300 sclk pulses: extra edges ignored
        push_tx(TXW);
        b_rxv = n_rxv; b_ferr = n_ferr;
        frame(PAT3, 300, 1'b0, '0, -1);
        check("ov_rx_data",   rx_data, PAT3);
        check("ov_rxv_cnt",   256'(n_rxv - b_rxv), 256'd1);
        check("ov_ferr_cnt",  256'(n_ferr - b_ferr), 256'd0);
        check("ov_miso",      mcap, {TXW, 128'h0});
        check("ov_busy",      256'(busy), 256'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
